// File: rtl/sm_conv_pkg.sv
// sm_conv_pkg: shared state encoding, mode codes and sizing helper for the sign-magnitude converter
package sm_conv_pkg;
   typedef enum logic [1:0] {IDLE, CONVERT, DONE} conv_state_t;
   localparam logic MODE_TC2SM = 1'b0;
   localparam logic MODE_SM2TC = 1'b1;
   function automatic int cnt_width(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/serial_negate_slice.sv
// serial_negate_slice: negates one BPC-bit slice LSB-first, carrying the seen-a-one flag across slices
module serial_negate_slice #(
   parameter int BPC = 1
) (
   input  logic [BPC-1:0] in_slice,
   input  logic           neg,
   input  logic           seen_one_in,
   output logic [BPC-1:0] out_slice,
   output logic           seen_one_out
);
   // copy bits up to and including the first one, invert the rest when negating
   always_comb begin : p_neg
      logic s;
      s = seen_one_in;
      out_slice = in_slice;
      for (int i = 0; i < BPC; i++) begin
         out_slice[i] = in_slice[i] ^ (neg & s);
         s = s | in_slice[i];
      end
      seen_one_out = s;
   end
endmodule

// File: rtl/serial_sign_magnitude_converter.sv
// serial_sign_magnitude_converter: multi-cycle two's complement <-> sign-magnitude converter
module serial_sign_magnitude_converter
   import sm_conv_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int BPC   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   input  logic             in_sign,
   input  logic [WIDTH-1:0] in_bits,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] out_bits,
   output logic             sign,
   output logic             overflow
);
   localparam int N  = WIDTH / BPC;
   localparam int CW = cnt_width(N);

   if (WIDTH % BPC != 0) begin : g_bad_bpc
      $error("WIDTH must be a multiple of BPC");
   end

   conv_state_t          state;
   logic [CW-1:0]        cnt;
   logic [WIDTH-1:0]     op_sh;
   logic [WIDTH-1:0]     res_sh;
   logic                 neg;
   logic                 seen;
   logic                 sign_r;
   logic                 ovf_r;
   logic [BPC-1:0]       slice_out;
   logic                 seen_next;
   logic [WIDTH+BPC-1:0] res_cat;

   assign res_cat = {slice_out, res_sh};

   serial_negate_slice #(.BPC(BPC)) u_slice (
      .in_slice     (op_sh[BPC-1:0]),
      .neg          (neg),
      .seen_one_in  (seen),
      .out_slice    (slice_out),
      .seen_one_out (seen_next)
   );

   // control FSM: capture on start, shift one slice per cycle, publish result on entry to DONE
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         op_sh    <= '0;
         res_sh   <= '0;
         neg      <= 1'b0;
         seen     <= 1'b0;
         sign_r   <= 1'b0;
         ovf_r    <= 1'b0;
         ready    <= 1'b1;
         done     <= 1'b0;
         out_bits <= '0;
         sign     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state  <= CONVERT;
               ready  <= 1'b0;
               cnt    <= '0;
               op_sh  <= in_bits;
               res_sh <= '0;
               seen   <= 1'b0;
               neg    <= mode == MODE_SM2TC ? in_sign : in_bits[WIDTH-1];
               sign_r <= mode == MODE_SM2TC ? in_sign & (|in_bits) : in_bits[WIDTH-1];
               ovf_r  <= mode == MODE_SM2TC &&
                         (in_sign ? in_bits[WIDTH-1] & (|in_bits[WIDTH-2:0]) : in_bits[WIDTH-1]);
            end
            CONVERT: begin
               op_sh  <= op_sh >> BPC;
               res_sh <= res_cat[WIDTH+BPC-1:BPC];
               seen   <= seen_next;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  out_bits <= res_cat[WIDTH+BPC-1:BPC];
                  sign     <= sign_r;
                  overflow <= ovf_r;
               end
            end
            DONE: begin
               state <= IDLE;
               ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_sign_magnitude_converter.sv
// tb_serial_sign_magnitude_converter: randomized and directed checks of BPC=1 and BPC=4 converters
module tb_serial_sign_magnitude_converter;
   localparam int W  = 8;
   localparam int NA = 8;
   localparam int NB = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         mode = 1'b0;
   logic         in_sign = 1'b0;
   logic [W-1:0] in_bits = '0;
   logic         a_ready, a_done, a_sign, a_ovf;
   logic         b_ready, b_done, b_sign, b_ovf;
   logic [W-1:0] a_out, b_out;
   int           tests = 0;
   int           fails = 0;

   always #5 clk = ~clk;

   serial_sign_magnitude_converter #(.WIDTH(W), .BPC(1)) dut_a (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .in_sign(in_sign), .in_bits(in_bits),
      .ready(a_ready), .done(a_done), .out_bits(a_out), .sign(a_sign), .overflow(a_ovf)
   );

   serial_sign_magnitude_converter #(.WIDTH(W), .BPC(4)) dut_b (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .in_sign(in_sign), .in_bits(in_bits),
      .ready(b_ready), .done(b_done), .out_bits(b_out), .sign(b_sign), .overflow(b_ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // value-level reference: {overflow, sign, out}
   function automatic logic [9:0] ref_model(input logic m, input logic s, input logic [7:0] b);
      int unsigned mag = b;
      int unsigned v;
      logic sg, ov;
      if (!m) begin
         v  = b[7] ? (256 - mag) % 256 : mag;
         sg = b[7];
         ov = 1'b0;
      end else begin
         v  = s ? (256 - mag) % 256 : mag;
         sg = s && mag != 0;
         ov = s ? mag > 128 : mag >= 128;
      end
      return {ov, sg, v[7:0]};
   endfunction

   task automatic wait_ready();
      for (int i = 0; i < 30 && !(a_ready && b_ready); i++) @(negedge clk);
      check("ready_idle", {a_ready, b_ready}, 2'b11);
   endtask

   task automatic do_op(input logic m, input logic s, input logic [7:0] b, input logic glitch);
      logic [9:0] exp = ref_model(m, s, b);
      logic [9:0] ra = '0, rb = '0;
      int la = 0, lb = 0;
      wait_ready();
      @(negedge clk);
      mode = m; in_sign = s; in_bits = b; start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (c == 1) start = 1'b0;
         if (glitch && c == 3) begin
            check("busy_ready", a_ready, 1'b0);
            start = 1'b1; in_bits = ~b; mode = ~m;
         end
         if (glitch && c == 4) start = 1'b0;
         if (a_done && la == 0) begin la = c; ra = {a_ovf, a_sign, a_out}; end
         if (b_done && lb == 0) begin lb = c; rb = {b_ovf, b_sign, b_out}; end
         if (la != 0 && lb != 0) break;
      end
      start = 1'b0;
      check("lat_a", la, NA + 1);
      check("lat_b", lb, NB + 1);
      check("res_a", ra, exp);
      check("res_b", rb, exp);
   endtask

   initial begin
      int first, second, dn;
      logic prev;
      repeat (3) @(posedge clk);
      #1;
      check("rst_a", {a_ready, a_done, a_out, a_sign, a_ovf}, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
      check("rst_b", {b_ready, b_done, b_out, b_sign, b_ovf}, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
      reset = 1'b1;

      do_op(1'b0, 1'b0, 8'h25, 1'b0);
      check("tc_25", {a_out, a_sign, a_ovf}, {8'h25, 1'b0, 1'b0});
      do_op(1'b0, 1'b0, 8'h80, 1'b0);
      check("tc_80", {a_out, a_sign, a_ovf}, {8'h80, 1'b1, 1'b0});
      do_op(1'b0, 1'b0, 8'h00, 1'b0);
      check("tc_00", {a_out, a_sign}, {8'h00, 1'b0});
      do_op(1'b1, 1'b1, 8'h0A, 1'b0);
      check("sm_0a", {a_out, a_sign, a_ovf}, {8'hF6, 1'b1, 1'b0});
      do_op(1'b1, 1'b1, 8'h80, 1'b0);
      check("sm_n80", {a_out, a_ovf}, {8'h80, 1'b0});
      do_op(1'b1, 1'b0, 8'h80, 1'b0);
      check("sm_p80", a_ovf, 1'b1);
      do_op(1'b1, 1'b1, 8'h00, 1'b0);
      check("sm_nz", {a_out, a_sign}, {8'h00, 1'b0});
      do_op(1'b0, 1'b0, 8'hF6, 1'b1);
      check("tc_f6", {a_out, a_sign, a_ovf, b_out}, {8'h0A, 1'b1, 1'b0, 8'h0A});

      wait_ready();
      @(negedge clk);
      mode = 1'b0; in_bits = 8'h33; start = 1'b1;
      first = 0; second = 0; prev = a_ready;
      for (int c = 1; c <= 40 && second == 0; c++) begin
         @(posedge clk); #1;
         if (prev && !a_ready) begin
            if (first == 0) first = c; else second = c;
         end
         prev = a_ready;
      end
      start = 1'b0;
      check("held_start", second - first, NA + 2);

      wait_ready();
      @(negedge clk);
      mode = 1'b0; in_bits = 8'h5C; start = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      reset = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_a", {a_ready, a_done, a_out, a_sign, a_ovf}, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
      check("mid_rst_b", {b_ready, b_out}, {1'b1, 8'h00});
      reset = 1'b1;
      dn = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         dn += (a_done | b_done) ? 1 : 0;
      end
      check("no_done_abort", dn, 0);

      for (int i = 0; i < 1000; i++)
         do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
